// File: rtl/if_id_reg_pkg.sv
// Shared definitions for the IF/ID pipeline register: NOP word, stall limit,
// register-field helpers and FSM state encoding.
package if_id_reg_pkg;

   localparam logic [31:0] NOP_INS_DEF  = 32'h0000_0000;
   localparam logic [3:0]  HOLD_MAX_DEF = 4'd15;

   typedef logic [4:0] reg_idx_t;
   typedef logic [1:0] state_t;

   localparam state_t ST_PRIME = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_HOLD  = 2'd2;

   function automatic reg_idx_t rs_of(input logic [31:0] ins);
      return ins[25:21];
   endfunction

   function automatic reg_idx_t rt_of(input logic [31:0] ins);
      return ins[20:16];
   endfunction

endpackage

// File: rtl/if_id_reg_if.sv
// Fetch/decode boundary signals of the IF/ID register; slave is the register,
// master is whoever drives fetch and observes decode.
interface if_id_reg_if;
   import if_id_reg_pkg::*;

   logic [31:0] if_ins;
   logic [31:0] if_npc;
   logic        if_pc_jump;
   logic        ex_mem_read;
   reg_idx_t    ex_rt;
   logic        stall_ext;
   logic [31:0] id_ins;
   logic [31:0] id_npc;
   logic        id_valid;
   logic        if_bubble;
   logic        ex_bubble;
   logic        hold_timeout;

   modport master (
      output if_ins, if_npc, if_pc_jump, ex_mem_read, ex_rt, stall_ext,
      input  id_ins, id_npc, id_valid, if_bubble, ex_bubble, hold_timeout
   );

   modport slave (
      input  if_ins, if_npc, if_pc_jump, ex_mem_read, ex_rt, stall_ext,
      output id_ins, id_npc, id_valid, if_bubble, ex_bubble, hold_timeout
   );

endinterface

// File: rtl/if_id_reg_load_use_detect.sv
// Combinational load-use hazard compare: a load in EX writing a register that
// the instruction in ID reads. Also reused by the forwarding unit.
module load_use_detect
   import if_id_reg_pkg::*;
(
   input  logic        id_valid,
   input  logic        mem_read,
   input  reg_idx_t    ex_rt,
   input  logic [31:0] ins,
   output logic        hazard
);

   // $0 is hardwired to zero, so a load targeting it never creates a dependency
   assign hazard = id_valid & mem_read & (ex_rt != 5'd0) &
                   ((ex_rt == rs_of(ins)) | (ex_rt == rt_of(ins)));

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with post-reset priming, load-use stall, redirect
// flush and a stall-duration watchdog.
//
// state | meaning
// PRIME | first edge after reset; fetch word is the pc=FFFF_FFFF artifact, drop it
// RUN   | normal capture of if_ins/if_npc each edge
// HOLD  | stalled; slot frozen until the stall condition clears
module if_id_reg
   import if_id_reg_pkg::*;
#(
   parameter logic [31:0] NOP_INS  = NOP_INS_DEF,
   parameter logic [3:0]  HOLD_MAX = HOLD_MAX_DEF
)(
   input logic        clk,
   input logic        rst,
   if_id_reg_if.slave bus
);

   state_t      state;
   logic [31:0] ins_q;
   logic [31:0] npc_q;
   logic        valid_q;
   logic [3:0]  hold_cnt;
   logic        hazard;
   logic        stall;
   logic        running;

   load_use_detect u_load_use_detect (
      .id_valid (valid_q),
      .mem_read (bus.ex_mem_read),
      .ex_rt    (bus.ex_rt),
      .ins      (ins_q),
      .hazard   (hazard)
   );

   assign running = (state != ST_PRIME);
   assign stall   = hazard | bus.stall_ext;

   assign bus.if_bubble    = running & stall;
   // EX already frozen by the external stall, so it must not also take a bubble
   assign bus.ex_bubble    = hazard & ~bus.stall_ext;
   assign bus.hold_timeout = running & stall & ~bus.if_pc_jump &
                             (hold_cnt == (HOLD_MAX - 4'd1));

   assign bus.id_ins   = valid_q ? ins_q : NOP_INS;
   assign bus.id_npc   = npc_q;
   assign bus.id_valid = valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_PRIME;
         ins_q    <= NOP_INS;
         npc_q    <= 32'h0;
         valid_q  <= 1'b0;
         hold_cnt <= 4'd0;
      end else if (bus.if_pc_jump) begin
         state    <= ST_RUN;
         ins_q    <= NOP_INS;
         valid_q  <= 1'b0;
         hold_cnt <= 4'd0;
      end else begin
         case (state)
            ST_PRIME: begin
               state   <= ST_RUN;
               ins_q   <= NOP_INS;
               valid_q <= 1'b0;
            end
            ST_RUN, ST_HOLD: begin
               if (stall) begin
                  state    <= ST_HOLD;
                  hold_cnt <= (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 4'd1;
               end else begin
                  state    <= ST_RUN;
                  ins_q    <= bus.if_ins;
                  npc_q    <= bus.if_npc;
                  valid_q  <= 1'b1;
                  hold_cnt <= 4'd0;
               end
            end
            default: begin
               state    <= ST_RUN;
               ins_q    <= NOP_INS;
               valid_q  <= 1'b0;
               hold_cnt <= 4'd0;
            end
         endcase
      end
   end

endmodule
